// File: rtl/mpc_rx_pkg.sv
// Shared definitions for the MPC receive sequencer: FSM state encoding,
// common widths and the idle-word (all-ones) detector.
package mpc_rx_pkg;

    localparam int STATE_W    = 3;
    localparam int ERRCNT_W   = 16;
    localparam int CNT_W      = 8;
    localparam int MAX_WORD_W = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_RUN    = 3'd3,
        ST_FRAME1 = 3'd4
    } state_e;

    // True when the low nbits of word are all ones (the MPC idle pattern).
    function automatic logic is_idle_word(input logic [MAX_WORD_W-1:0] word, input int nbits);
        logic idle;
        idle = 1'b1;
        for (int i = 0; i < MAX_WORD_W; i++) begin
            if (i < nbits && !word[i]) begin
                idle = 1'b0;
            end
        end
        return idle;
    endfunction

endpackage

// File: rtl/mpc_rx_err_counter.sv
// Saturating error counter for the MPC receive sequencer.
// Only compiled when MPC_RX_ERRCNT_EN is defined; without it the sequencer
// ties its error count to zero and this module does not exist.
`ifdef MPC_RX_ERRCNT_EN
module mpc_rx_err_counter
    import mpc_rx_pkg::*;
#(
    parameter int W = ERRCNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear has priority; increments stop at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, asynchronously cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`endif

// File: rtl/mpc_rx_sequencer.sv
// MPC 80MHz DDR receive sequencer: holds the demux in async set, lets its
// output settle, qualifies a run of idle (all-ones) words, then assembles
// two-bx MPC frames from the 1st/2nd time slices.
// Optional feature macro: MPC_RX_ERRCNT_EN enables the saturating error count.
//
// Handshake: frame_valid is a one-clock pulse with no backpressure;
// frame_data is valid in that clock and holds its value until the next pulse.
module mpc_rx_sequencer
    import mpc_rx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int HOLD_CYC   = 8,
    parameter int SETTLE_CYC = 4,
    parameter int IDLE_REQ   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_enable,
    input  logic                 resync,
    input  logic [WIDTH-1:0]     dout1st,
    input  logic [WIDTH-1:0]     dout2nd,
    output logic                 demux_set,
    output logic                 rx_ready,
    output logic                 frame_valid,
    output logic [4*WIDTH-1:0]   frame_data,
    output logic [STATE_W-1:0]   state_dbg,
    output logic [ERRCNT_W-1:0]  err_count
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_REQ - 1);

    state_e                 state_q;
    state_e                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [2*WIDTH-1:0]     w0_q;
    logic                   frame_valid_q;
    logic [4*WIDTH-1:0]     frame_data_q;

    logic [2*WIDTH-1:0]     word;
    logic [MAX_WORD_W-1:0]  word_ext;
    logic                   word_idle;
    logic                   frame_start;
    logic                   frame_done;

    assign word = {dout2nd, dout1st};

    // Idle detection on the full two-slice word; a low bit 0 of the first slice marks a start.
    always_comb begin
        word_ext                = '0;
        word_ext[2*WIDTH-1:0]   = word;
        word_idle               = is_idle_word(word_ext, 2 * WIDTH);
        frame_start             = (state_q == ST_RUN) && !dout1st[0];
        frame_done              = (state_q == ST_FRAME1) && rx_enable && !resync;
    end

    // State register and shared cycle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; resync or a dropped enable forces HOLD and drops any partial frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (resync || (!rx_enable && state_q != ST_HOLD)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (rx_enable) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d = ST_SETTLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_CHECK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (word_idle) begin
                        if (cnt_q == IDLE_LAST) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!dout1st[0]) begin
                        state_d = ST_FRAME1;
                    end
                end
                ST_FRAME1: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        demux_set = (state_q == ST_HOLD);
        rx_ready  = (state_q == ST_RUN) || (state_q == ST_FRAME1);
        state_dbg = state_q;
    end

    // Frame assembly: capture w0 on a start, publish {w1,w0} the clock after FRAME1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w0_q          <= '0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
        end else begin
            frame_valid_q <= frame_done;
            if (frame_start) begin
                w0_q <= word;
            end
            if (frame_done) begin
                frame_data_q <= {word, w0_q};
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;

`ifdef MPC_RX_ERRCNT_EN
    logic err_event;

    // One error per clock at most: idle mismatch in CHECK or corrupt idle in RUN.
    always_comb begin
        err_event = 1'b0;
        if (rx_enable && !resync) begin
            if (state_q == ST_CHECK && !word_idle) begin
                err_event = 1'b1;
            end
            if (state_q == ST_RUN && dout1st[0] && !word_idle) begin
                err_event = 1'b1;
            end
        end
    end

    mpc_rx_err_counter #(
        .W (ERRCNT_W)
    ) u_err_counter (
        .clk_i   (clock),
        .rst_i   (reset),
        .inc_i   (err_event),
        .clr_i   (resync),
        .count_o (err_count)
    );
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_mpc_rx_sequencer.sv
// Directed bench for mpc_rx_sequencer: bring-up timing, idle qualification
// with an injected error, table of frame vectors, abort and re-enable,
// error saturation / resync, and asynchronous reset mid-frame.
module tb_mpc_rx_sequencer;

    logic        clock;
    logic        reset;
    logic        rx_enable;
    logic        resync;
    logic [7:0]  dout1st;
    logic [7:0]  dout2nd;
    logic        demux_set;
    logic        rx_ready;
    logic        frame_valid;
    logic [31:0] frame_data;
    logic [2:0]  state_dbg;
    logic [15:0] err_count;

    int n_vec;
    int n_err;

`ifdef MPC_RX_ERRCNT_EN
    localparam logic [15:0] E1  = 16'd1;
    localparam logic [15:0] E2  = 16'd2;
    localparam logic [15:0] ESAT = 16'hFFFF;
    localparam int CORRUPT_N = 70000;
`else
    localparam logic [15:0] E1  = 16'd0;
    localparam logic [15:0] E2  = 16'd0;
    localparam logic [15:0] ESAT = 16'd0;
    localparam int CORRUPT_N = 100;
`endif

    typedef struct {
        logic        en;
        logic        rs;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [2:0]  st;
        logic        ds;
        logic        rdy;
        logic        fv;
        logic [31:0] fd;
        logic [15:0] err;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    mpc_rx_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .rx_enable   (rx_enable),
        .resync      (resync),
        .dout1st     (dout1st),
        .dout2nd     (dout2nd),
        .demux_set   (demux_set),
        .rx_ready    (rx_ready),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .state_dbg   (state_dbg),
        .err_count   (err_count)
    );

    // Clock: 10 ns period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        dout1st = 8'hFF;
        dout2nd = 8'hFF;
    endtask

    // From HOLD with counter 0 and idle inputs: 8 HOLD, 4 SETTLE, 16 CHECK clocks, then RUN.
    task automatic bring_up(input string tag);
        logic [2:0] exp_st;
        for (int i = 1; i <= 28; i++) begin
            tick();
            exp_st = (i < 8) ? 3'd0 : (i < 12) ? 3'd1 : (i < 28) ? 3'd2 : 3'd3;
            check({tag, "_state"}, 32'(state_dbg), 32'(exp_st));
            check({tag, "_demux_set"}, 32'(demux_set), 32'(i < 8));
            check({tag, "_rx_ready"}, 32'(rx_ready), 32'(i == 28));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        //           en    rs    d1     d2     st    ds    rdy   fv    fd              err
        vecs[0]  = '{1'b1, 1'b0, 8'h3C, 8'hA5, 3'd4, 1'b0, 1'b1, 1'b0, 32'h0000_0000, E1};
        vecs[1]  = '{1'b1, 1'b0, 8'h34, 8'h12, 3'd3, 1'b0, 1'b1, 1'b1, 32'h1234_A53C, E1};
        vecs[2]  = '{1'b1, 1'b0, 8'hFF, 8'hFF, 3'd3, 1'b0, 1'b1, 1'b0, 32'h1234_A53C, E1};
        vecs[3]  = '{1'b1, 1'b0, 8'h02, 8'h11, 3'd4, 1'b0, 1'b1, 1'b0, 32'h1234_A53C, E1};
        vecs[4]  = '{1'b1, 1'b0, 8'hFE, 8'h22, 3'd3, 1'b0, 1'b1, 1'b1, 32'h22FE_1102, E1};
        vecs[5]  = '{1'b1, 1'b0, 8'h44, 8'h33, 3'd4, 1'b0, 1'b1, 1'b0, 32'h22FE_1102, E1};
        vecs[6]  = '{1'b1, 1'b0, 8'h66, 8'h55, 3'd3, 1'b0, 1'b1, 1'b1, 32'h5566_3344, E1};
        vecs[7]  = '{1'b1, 1'b0, 8'h88, 8'h77, 3'd4, 1'b0, 1'b1, 1'b0, 32'h5566_3344, E1};
        vecs[8]  = '{1'b1, 1'b0, 8'hAA, 8'h99, 3'd3, 1'b0, 1'b1, 1'b1, 32'h99AA_7788, E1};
        vecs[9]  = '{1'b1, 1'b0, 8'hFF, 8'hFF, 3'd3, 1'b0, 1'b1, 1'b0, 32'h99AA_7788, E1};
        vecs[10] = '{1'b1, 1'b0, 8'h81, 8'hFF, 3'd3, 1'b0, 1'b1, 1'b0, 32'h99AA_7788, E2};

        // Reset values.
        reset     = 1'b1;
        rx_enable = 1'b1;
        resync    = 1'b0;
        set_idle();
        repeat (2) @(posedge clock);
        #1;
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_demux_set", 32'(demux_set), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_data", frame_data, 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // 1) Bring-up with idle line.
        bring_up("t1");
        check("t1_err_count", 32'(err_count), 32'd0);

        // 2) Idle qualification restarts on a bad word at count 10.
        resync = 1'b1;
        tick();
        resync = 1'b0;
        check("t2_resync_state", 32'(state_dbg), 32'd0);
        repeat (12) tick();
        check("t2_in_check", 32'(state_dbg), 32'd2);
        repeat (10) tick();
        dout2nd = 8'h7F;
        tick();
        set_idle();
        check("t2_bad_word_state", 32'(state_dbg), 32'd2);
        repeat (15) tick();
        check("t2_before_run", 32'(state_dbg), 32'd2);
        check("t2_not_ready", 32'(rx_ready), 32'd0);
        tick();
        check("t2_run", 32'(state_dbg), 32'd3);
        check("t2_err_count", 32'(err_count), 32'(E1));

        // 3/4) Single frame, back-to-back frames, corrupt idle.
        for (int i = 0; i < NV; i++) begin
            rx_enable = vecs[i].en;
            resync    = vecs[i].rs;
            dout1st   = vecs[i].d1;
            dout2nd   = vecs[i].d2;
            tick();
            check($sformatf("v%0d_state", i), 32'(state_dbg), 32'(vecs[i].st));
            check($sformatf("v%0d_demux_set", i), 32'(demux_set), 32'(vecs[i].ds));
            check($sformatf("v%0d_rx_ready", i), 32'(rx_ready), 32'(vecs[i].rdy));
            check($sformatf("v%0d_frame_valid", i), 32'(frame_valid), 32'(vecs[i].fv));
            check($sformatf("v%0d_frame_data", i), frame_data, vecs[i].fd);
            check($sformatf("v%0d_err_count", i), 32'(err_count), 32'(vecs[i].err));
        end
        set_idle();

        // 5) Enable drops during FRAME1: partial frame dropped, back to HOLD.
        dout1st = 8'h10;
        dout2nd = 8'h20;
        tick();
        check("t5_frame1", 32'(state_dbg), 32'd4);
        dout1st   = 8'h30;
        dout2nd   = 8'h40;
        rx_enable = 1'b0;
        tick();
        set_idle();
        check("t5_abort_state", 32'(state_dbg), 32'd0);
        check("t5_abort_demux_set", 32'(demux_set), 32'd1);
        check("t5_abort_no_valid", 32'(frame_valid), 32'd0);
        tick();
        check("t5_hold_no_valid", 32'(frame_valid), 32'd0);
        check("t5_hold_state", 32'(state_dbg), 32'd0);
        check("t5_data_kept", frame_data, 32'h99AA_7788);
        rx_enable = 1'b1;
        bring_up("t5");

        // 6) Corrupt idle words in RUN, then resync clears count (resync wins).
        dout1st = 8'hFF;
        dout2nd = 8'h00;
        for (int i = 0; i < CORRUPT_N; i++) begin
            tick();
        end
        check("t6_state_run", 32'(state_dbg), 32'd3);
        check("t6_err_sat", 32'(err_count), 32'(ESAT));
        resync = 1'b1;
        tick();
        resync = 1'b0;
        set_idle();
        check("t6_resync_err", 32'(err_count), 32'd0);
        check("t6_resync_state", 32'(state_dbg), 32'd0);
        check("t6_resync_demux_set", 32'(demux_set), 32'd1);

        // Asynchronous reset in the middle of a frame.
        bring_up("t7");
        dout1st = 8'h00;
        dout2nd = 8'h01;
        tick();
        check("t7_frame1", 32'(state_dbg), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check("t7_rst_state", 32'(state_dbg), 32'd0);
        check("t7_rst_frame_data", frame_data, 32'd0);
        check("t7_rst_frame_valid", 32'(frame_valid), 32'd0);
        check("t7_rst_demux_set", 32'(demux_set), 32'd1);
        tick();
        reset = 1'b0;
        set_idle();
        tick();
        check("t7_post_no_valid", 32'(frame_valid), 32'd0);
        check("t7_post_state", 32'(state_dbg), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
